// File: rtl/alu.sv
// Registered 8-function ALU with one-cycle latency and synchronous active-high reset.
// Optional feature macro: ALU_FLAGS_EN adds the registered alu_flags port {carry, overflow, negative, zero}.
module alu #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic [2:0]            opcode_in,
  input  logic [DATA_WIDTH-1:0] alu_input1,
  input  logic [DATA_WIDTH-1:0] alu_input2,
  output logic [DATA_WIDTH-1:0] alu_output
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]            alu_flags
`endif
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  op_e                  op_s;
  logic [2:0]           shamt_s;
  logic [DATA_WIDTH-1:0] result_d;
  logic [DATA_WIDTH-1:0] result_q;

  assign op_s    = op_e'(opcode_in);
  assign shamt_s = alu_input2[2:0];

  always_comb begin
    result_d = '0;
    case (op_s)
      OP_ADD:  result_d = alu_input1 + alu_input2;
      OP_SUB:  result_d = alu_input1 - alu_input2;
      OP_AND:  result_d = alu_input1 & alu_input2;
      OP_OR:   result_d = alu_input1 | alu_input2;
      OP_XOR:  result_d = alu_input1 ^ alu_input2;
      OP_SHL:  result_d = alu_input1 << shamt_s;
      OP_SHR:  result_d = alu_input1 >> shamt_s;
      OP_SLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, (alu_input1 < alu_input2)};
      default: result_d = '0;
    endcase
  end

  // Reset wins over enable; disabled edges hold the previous result.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      result_q <= '0;
    end else if (enable_in) begin
      result_q <= result_d;
    end
  end

  assign alu_output = result_q;

`ifdef ALU_FLAGS_EN
  logic [DATA_WIDTH:0]   sum_wide_s;
  logic [DATA_WIDTH:0]   diff_wide_s;
  logic [DATA_WIDTH:0]   shl_wide_s;
  logic [DATA_WIDTH:0]   shr_wide_s;
  logic                  carry_d;
  logic                  overflow_d;
  logic [3:0]            flags_d;
  logic [3:0]            flags_q;

  // The extra bit of each widened operation holds the bit that leaves the result.
  assign sum_wide_s  = {1'b0, alu_input1} + {1'b0, alu_input2};
  assign diff_wide_s = {1'b0, alu_input1} - {1'b0, alu_input2};
  assign shl_wide_s  = {1'b0, alu_input1} << shamt_s;
  assign shr_wide_s  = {alu_input1, 1'b0} >> shamt_s;

  always_comb begin
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_s)
      OP_ADD: begin
        carry_d    = sum_wide_s[DATA_WIDTH];
        overflow_d = (alu_input1[MSB] == alu_input2[MSB]) &&
                     (sum_wide_s[MSB] != alu_input1[MSB]);
      end
      OP_SUB: begin
        carry_d    = diff_wide_s[DATA_WIDTH];
        overflow_d = (alu_input1[MSB] != alu_input2[MSB]) &&
                     (diff_wide_s[MSB] != alu_input1[MSB]);
      end
      OP_SHL:  carry_d = shl_wide_s[DATA_WIDTH];
      OP_SHR:  carry_d = shr_wide_s[0];
      default: begin
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
  end

  assign flags_d = {carry_d, overflow_d, result_d[MSB], (result_d == '0)};

  // Flags follow exactly the same reset/enable rules as the result.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      flags_q <= 4'b0000;
    end else if (enable_in) begin
      flags_q <= flags_d;
    end
  end

  assign alu_flags = flags_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Randomised and directed self-checking bench for alu against an arithmetic reference model.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
`ifdef ALU_FLAGS_EN
  logic [3:0] flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int exp_out   = 0;
  int exp_flags = 0;

  alu #(.DATA_WIDTH(8)) dut (
    .clock_in   (clk),
    .reset_in   (rst),
    .enable_in  (en),
    .opcode_in  (op),
    .alu_input1 (a),
    .alu_input2 (b),
    .alu_output (out)
`ifdef ALU_FLAGS_EN
    ,
    .alu_flags  (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  task automatic model(input int opc, input int av, input int bv, output int r, output int f);
    int n, sa, sb, sr, c, v;
    n = bv % 8;
    sa = (av > 127) ? av - 256 : av;
    sb = (bv > 127) ? bv - 256 : bv;
    c = 0;
    v = 0;
    case (opc)
      0: begin r = (av + bv) % 256; c = (av + bv > 255) ? 1 : 0;
               sr = sa + sb; v = (sr > 127 || sr < -128) ? 1 : 0; end
      1: begin r = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0;
               sr = sa - sb; v = (sr > 127 || sr < -128) ? 1 : 0; end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin r = (av * (2 ** n)) % 256; c = (n == 0) ? 0 : (av / (2 ** (8 - n))) % 2; end
      6: begin r = av / (2 ** n); c = (n == 0) ? 0 : (av / (2 ** (n - 1))) % 2; end
      7: r = (av < bv) ? 1 : 0;
      default: r = 0;
    endcase
    f = c * 8 + v * 4 + ((r >= 128) ? 2 : 0) + ((r == 0) ? 1 : 0);
  endtask

  task automatic step(input string tag, input logic r_in, input logic e_in,
                      input int opc, input int av, input int bv);
    int r, f;
    @(negedge clk);
    rst = r_in;
    en  = e_in;
    op  = 3'(opc);
    a   = 8'(av);
    b   = 8'(bv);
    @(posedge clk);
    #1;
    if (r_in) begin
      exp_out   = 0;
      exp_flags = 0;
    end else if (e_in) begin
      model(opc, av, bv, r, f);
      exp_out   = r;
      exp_flags = f;
    end
    check({tag, "_noX"}, int'($isunknown(out)), 0);
    check(tag, int'(out), exp_out);
`ifdef ALU_FLAGS_EN
    check({tag, "_flags"}, int'(flags), exp_flags);
`endif
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    op  = 3'b000;
    a   = 8'h00;
    b   = 8'h00;

    step("reset", 1'b1, 1'b0, 0, 0, 0);
    step("reset_en", 1'b1, 1'b1, 0, 8'hFF, 8'h01);
    check("reset_const", int'(out), 8'h00);
`ifdef ALU_FLAGS_EN
    check("reset_flags_const", int'(flags), 4'b0000);
`endif

    step("add00", 1'b0, 1'b1, 0, 0, 0);
    step("add01", 1'b0, 1'b1, 0, 0, 1);
    step("add10", 1'b0, 1'b1, 0, 1, 0);
    step("add11", 1'b0, 1'b1, 0, 1, 1);
    check("add11_const", int'(out), 8'h02);
    step("add_ff", 1'b0, 1'b1, 0, 8'hFF, 8'h01);
    check("add_ff_const", int'(out), 8'h00);
`ifdef ALU_FLAGS_EN
    check("add_ff_zc", int'(flags & 4'b1001), 4'b1001);
`endif

    step("sub", 1'b0, 1'b1, 1, 8'h00, 8'h01);
    check("sub_const", int'(out), 8'hFF);
`ifdef ALU_FLAGS_EN
    check("sub_nc", int'(flags & 4'b1010), 4'b1010);
`endif
    step("slt35", 1'b0, 1'b1, 7, 3, 5);
    check("slt35_const", int'(out), 8'h01);
    step("slt53", 1'b0, 1'b1, 7, 5, 3);
    check("slt53_const", int'(out), 8'h00);

    step("and", 1'b0, 1'b1, 2, 8'hF0, 8'h3C);
    check("and_const", int'(out), 8'h30);
    step("or", 1'b0, 1'b1, 3, 8'hF0, 8'h3C);
    check("or_const", int'(out), 8'hFC);
    step("xor", 1'b0, 1'b1, 4, 8'hF0, 8'h3C);
    check("xor_const", int'(out), 8'hCC);
    step("shl", 1'b0, 1'b1, 5, 8'h81, 8'h09);
    check("shl_const", int'(out), 8'h02);
`ifdef ALU_FLAGS_EN
    check("shl_c", int'(flags[3]), 1);
`endif
    step("shr", 1'b0, 1'b1, 6, 8'h81, 8'h09);
    check("shr_const", int'(out), 8'h40);
`ifdef ALU_FLAGS_EN
    check("shr_c", int'(flags[3]), 1);
`endif

    step("hold_add", 1'b0, 1'b1, 0, 2, 3);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b0, 0, 7, 7);
      check("hold_const", int'(out), 8'h05);
    end
    step("hold_resume", 1'b0, 1'b1, 0, 7, 7);
    check("hold_resume_const", int'(out), 8'h0E);

    step("ovf", 1'b0, 1'b1, 0, 8'h7F, 8'h01);
    check("ovf_const", int'(out), 8'h80);
`ifdef ALU_FLAGS_EN
    check("ovf_flags", int'(flags), 4'b0110);
`endif

    step("pre_rst", 1'b0, 1'b1, 0, 8'h10, 8'h20);
    step("mid_rst", 1'b1, 1'b1, 0, 8'h11, 8'h22);
    check("mid_rst_const", int'(out), 8'h00);
    step("post_rst", 1'b0, 1'b1, 4, 8'hAA, 8'h0F);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(19) == 0), ($urandom_range(3) != 0),
           int'($urandom_range(7)), int'($urandom_range(255)), int'($urandom_range(255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
